// File: rtl/bargraph_seq_if.sv
// Bus bundle for the progress bar-graph driver.
// master: timer core side (drives seconds, load, blink), slave: bargraph_seq.
interface bargraph_seq_if #(
  parameter int N_SEG = 8,
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] timer_seconds;
  logic [WIDTH-1:0] prog_seconds;
  logic             load;
  logic             blink_en;
  logic             blink_tick;
  logic [N_SEG-1:0] led;
  logic             ready;

  modport master (
    output timer_seconds,
    output prog_seconds,
    output load,
    output blink_en,
    output blink_tick,
    input  led,
    input  ready
  );

  modport slave (
    input  timer_seconds,
    input  prog_seconds,
    input  load,
    input  blink_en,
    input  blink_tick,
    output led,
    output ready
  );
endinterface

// File: rtl/bargraph_seq.sv
// Egg-timer progress bar-graph: lights N_SEG LEDs in proportion to
// elapsed vs programmed seconds, with an optional blinking lead segment.
// Ports: clk, rst (async, active-high), bus (bargraph_seq_if.slave):
//   timer_seconds, prog_seconds, load, blink_en, blink_tick -> led, ready.
module bargraph_seq #(
  parameter int N_SEG = 8,
  parameter int WIDTH = 12
) (
  input logic           clk,
  input logic           rst,
  bargraph_seq_if.slave bus
);

  // RW holds a partial remainder up to 2*N_SEG-1.
  localparam int RW = $clog2(N_SEG) + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int KW = $clog2(N_SEG);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    STEP,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  // quo_q is the dividend shifter during DIV and holds base afterwards.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [RW-1:0]    accr_q, accr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] thr_q [1:N_SEG-1];
  logic             ready_q, ready_d;
  logic             phase_q, phase_d;
  logic [N_SEG-1:0] led_q, led_d;

  logic [RW-1:0]    r_sh;
  logic [RW-1:0]    r_sub;
  logic             div_ge;
  logic [WIDTH-1:0] sq;
  logic [RW-1:0]    sr;
  logic [WIDTH-1:0] t_val;
  logic             thr_we;

  // Restoring division step: shift in the next dividend bit.
  always_comb begin
    r_sh   = {rem_q[RW-2:0], quo_q[WIDTH-1]};
    div_ge = (r_sh >= RW'(N_SEG));
    r_sub  = r_sh - RW'(N_SEG);
  end

  // Threshold stepper: (q, r) tracks k*P/N_SEG as quotient/remainder.
  always_comb begin
    sq = acc_q + quo_q;
    sr = accr_q + rem_q;
    if (sr >= RW'(N_SEG)) begin
      sr = sr - RW'(N_SEG);
      sq = sq + WIDTH'(1);
    end
    t_val = sq + WIDTH'(sr != '0);
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    accr_d  = accr_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    thr_we  = 1'b0;
    if (bus.load) begin
      state_d = DIV;
      p_d     = bus.prog_seconds;
      quo_d   = bus.prog_seconds;
      rem_d   = '0;
      acc_d   = '0;
      accr_d  = '0;
      cnt_d   = '0;
      k_d     = KW'(1);
    end else begin
      unique case (state_q)
        DIV: begin
          quo_d = {quo_q[WIDTH-2:0], div_ge};
          rem_d = div_ge ? r_sub : r_sh;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1))
            state_d = STEP;
        end
        STEP: begin
          acc_d  = sq;
          accr_d = sr;
          thr_we = 1'b1;
          k_d    = k_q + KW'(1);
          if (k_q == KW'(N_SEG - 1))
            state_d = DONE;
        end
        IDLE, DONE: begin
        end
      endcase
    end
  end

  // Ready is registered off DONE, giving one settle cycle after STEP.
  assign ready_d = (state_q == DONE) && !bus.load;

  logic [N_SEG-1:0] dec;
  logic [N_SEG-1:0] shown;
  logic [KW-1:0]    hi;
  logic             nz;
  logic             blink_on;

  always_comb begin
    phase_d = phase_q ^ bus.blink_tick;
    nz      = (bus.timer_seconds != '0);
    dec     = '0;
    dec[0]  = nz;
    for (int k = 1; k < N_SEG; k++)
      dec[k] = nz && (bus.timer_seconds >= thr_q[k]);
    hi = '0;
    for (int k = 0; k < N_SEG; k++)
      if (dec[k])
        hi = KW'(k);
    // New phase is used so a tick shows on led one edge later.
    blink_on = bus.blink_en && phase_d && nz &&
               (bus.timer_seconds < p_q);
    shown = dec;
    if (blink_on)
      shown[hi] = 1'b0;
    led_d = ready_q ? shown : led_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      accr_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      ready_q <= 1'b0;
      phase_q <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      accr_q  <= accr_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < N_SEG; k++)
        thr_q[k] <= '0;
    end else if (thr_we) begin
      thr_q[k_q] <= t_val;
    end
  end

  assign bus.led   = led_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_bargraph_seq.sv
// Self-checking bench for bargraph_seq.
// Default instance (8 seg, 12 bit) plus a 5 seg, 8 bit sweep instance.
module tb_bargraph_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;
  logic ph;
  logic [11:0] cur_p;

  always #5 clk = ~clk;

  bargraph_seq_if #(.N_SEG(8), .WIDTH(12)) b8 ();
  bargraph_seq_if #(.N_SEG(5), .WIDTH(8))  b5 ();

  bargraph_seq #(.N_SEG(8), .WIDTH(12)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  bargraph_seq #(.N_SEG(5), .WIDTH(8)) u5 (
    .clk (clk),
    .rst (rst),
    .bus (b5)
  );

  typedef struct {
    logic [11:0] p;
    logic [11:0] t;
    logic [7:0]  led;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; load is sampled at the next posedge (edge 0).
  task automatic load8(input logic [11:0] p, input int lat);
    b8.prog_seconds = p;
    b8.load = 1'b1;
    @(negedge clk);
    b8.load = 1'b0;
    n = 1;
    while (!b8.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_latency8", n, lat);
    cur_p = p;
  endtask

  task automatic load5(input logic [7:0] p, input int lat);
    b5.prog_seconds = p;
    b5.load = 1'b1;
    @(negedge clk);
    b5.load = 1'b0;
    n = 1;
    while (!b5.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_latency5", n, lat);
  endtask

  task automatic tmr8(input logic [11:0] t, input logic [7:0] exp,
                      input string nm);
    b8.timer_seconds = t;
    @(negedge clk);
    check(nm, b8.led, exp);
  endtask

  task automatic tmr5(input logic [7:0] t, input logic [4:0] exp,
                      input string nm);
    b5.timer_seconds = t;
    @(negedge clk);
    check(nm, b5.led, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{80, 35, 8'h0F};
    vt[1]  = '{80, 9, 8'h01};
    vt[2]  = '{80, 10, 8'h03};
    vt[3]  = '{80, 69, 8'h7F};
    vt[4]  = '{80, 70, 8'hFF};
    vt[5]  = '{83, 31, 8'h07};
    vt[6]  = '{83, 32, 8'h0F};
    vt[7]  = '{83, 83, 8'hFF};
    vt[8]  = '{83, 0, 8'h00};
    vt[9]  = '{83, 72, 8'h7F};
    vt[10] = '{83, 73, 8'hFF};
    vt[11] = '{83, 4095, 8'hFF};
    vt[12] = '{83, 10, 8'h01};
    vt[13] = '{83, 11, 8'h03};
    vt[14] = '{83, 52, 8'h3F};
    vt[15] = '{0, 5, 8'hFF};
    vt[16] = '{0, 0, 8'h00};
    vt[17] = '{0, 4095, 8'hFF};

    rst = 1'b1;
    b8.timer_seconds = '0;
    b8.prog_seconds  = '0;
    b8.load          = 1'b0;
    b8.blink_en      = 1'b0;
    b8.blink_tick    = 1'b0;
    b5.timer_seconds = '0;
    b5.prog_seconds  = '0;
    b5.load          = 1'b0;
    b5.blink_en      = 1'b0;
    b5.blink_tick    = 1'b0;
    ph = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_led", b8.led, 8'h00);
    check("reset_ready", b8.ready, 1'b0);
    rst = 1'b0;
    b8.timer_seconds = 12'd50;
    repeat (3) @(negedge clk);
    check("idle_ready", b8.ready, 1'b0);
    check("idle_led", b8.led, 8'h00);

    // P = 80: 20-cycle load, then first tracked update.
    load8(12'd80, 21);
    tmr8(12'd35, 8'h0F, "p80_t35");

    for (int i = 0; i < 18; i++) begin
      if (vt[i].p != cur_p)
        load8(vt[i].p, 21);
      tmr8(vt[i].t, vt[i].led, $sformatf("vec%0d", i));
    end

    // Blink on the leading segment.
    load8(12'd80, 21);
    b8.blink_en = 1'b1;
    tmr8(12'd35, 8'h0F, "blink_start");
    for (int i = 0; i < 6; i++) begin
      b8.blink_tick = 1'b1;
      @(negedge clk);
      b8.blink_tick = 1'b0;
      ph = ~ph;
      check($sformatf("blink%0d", i), b8.led, ph ? 8'h07 : 8'h0F);
      @(negedge clk);
      check($sformatf("blink_hold%0d", i), b8.led,
            ph ? 8'h07 : 8'h0F);
    end
    b8.timer_seconds = 12'd80;
    for (int i = 0; i < 4; i++) begin
      b8.blink_tick = 1'b1;
      @(negedge clk);
      b8.blink_tick = 1'b0;
      ph = ~ph;
      check($sformatf("blink_full%0d", i), b8.led, 8'hFF);
    end
    b8.blink_en = 1'b0;

    // Re-load mid-DIV at edge 5; led holds meanwhile.
    b8.prog_seconds = 12'd80;
    b8.load = 1'b1;
    @(negedge clk);
    b8.load = 1'b0;
    b8.timer_seconds = 12'd1;
    repeat (4) @(negedge clk);
    check("mid_ready", b8.ready, 1'b0);
    check("mid_hold", b8.led, 8'hFF);
    load8(12'd16, 21);
    tmr8(12'd13, 8'h7F, "p16_t13");
    tmr8(12'd14, 8'hFF, "p16_t14");
    tmr8(12'd2, 8'h03, "p16_t2");
    tmr8(12'd3, 8'h03, "p16_t3");
    tmr8(12'd4, 8'h07, "p16_t4");
    tmr8(12'd1, 8'h01, "p16_t1");

    // Reset mid-STEP.
    tmr8(12'd35, 8'hFF, "pre_rst");
    b8.prog_seconds = 12'd83;
    b8.load = 1'b1;
    @(negedge clk);
    b8.load = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_led", b8.led, 8'h00);
    check("rst_ready", b8.ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ph = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_ready", b8.ready, 1'b0);
    check("post_rst_led", b8.led, 8'h00);
    load8(12'd83, 21);
    tmr8(12'd32, 8'h0F, "reload_t32");

    // Sweep: N_SEG = 5, WIDTH = 8, P = 7 -> T = 2, 3, 5, 6.
    load5(8'd7, 14);
    tmr5(8'd4, 5'h07, "n5_t4");
    tmr5(8'd1, 5'h01, "n5_t1");
    tmr5(8'd2, 5'h03, "n5_t2");
    tmr5(8'd3, 5'h07, "n5_t3");
    tmr5(8'd5, 5'h0F, "n5_t5");
    tmr5(8'd6, 5'h1F, "n5_t6");
    tmr5(8'd0, 5'h00, "n5_t0");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
